// File: rtl/factor_pkg.sv
// Shared encodings for the factor game: external game-state codes, the
// answer judge's internal states and a small digit helper.
package factor_pkg;

    typedef enum logic [3:0] {
        GS_READY = 4'b0010,
        GS_QUE   = 4'b0011,
        GS_INPUT = 4'b0100,
        GS_WRONG = 4'b0111,
        GS_GOOD  = 4'b1000,
        GS_LOSE  = 4'b1011
    } game_state_e;

    typedef enum logic [1:0] {
        JS_IDLE = 2'd0,
        JS_MUL1 = 2'd1,
        JS_MUL2 = 2'd2,
        JS_CMP  = 2'd3
    } judge_state_e;

    localparam logic [1:0] MISS_MAX = 2'd3;

    // Only single-digit primes are legal factor answers.
    function automatic logic is_prime_digit(input logic [3:0] d);
        return (d == 4'd2) || (d == 4'd3) || (d == 4'd5) || (d == 4'd7);
    endfunction

endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational three-digit BCD to binary converter with a flag that is low
// when any digit lies outside 0..9.
module bcd3_to_bin (
    input  logic [11:0] bcd,
    output logic [9:0]  bin,
    output logic        digits_ok
);

    logic [9:0] hundreds;
    logic [9:0] tens;
    logic [9:0] ones;

    // Out-of-range digits may wrap the 10-bit sum; digits_ok flags that case.
    always_comb begin
        hundreds  = {6'd0, bcd[11:8]};
        tens      = {6'd0, bcd[7:4]};
        ones      = {6'd0, bcd[3:0]};
        digits_ok = (bcd[11:8] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
        bin       = hundreds * 10'd100 + tens * 10'd10 + ones;
    end

endmodule

// File: rtl/answer_judge.sv
// Judges whether three prime BCD digits multiply to the three-digit BCD target,
// with a fixed four-edge latency, a saturating miss counter and a lose flag.
module answer_judge (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  STATE,
    input  logic [23:0] QUESTION,
    input  logic [3:0]  ANS1,
    input  logic [3:0]  ANS2,
    input  logic [3:0]  ANS3,
    input  logic        DEC,
    output logic        BUSY,
    output logic        JUDGE_VALID,
    output logic        JUDGE_OK,
    output logic [1:0]  MISS_CNT,
    output logic        LOSE_FLAG
);

    import factor_pkg::*;

    judge_state_e state_q, state_d;

    logic [3:0]  a1_q, a1_d;
    logic [3:0]  a2_q, a2_d;
    logic [3:0]  a3_q, a3_d;
    logic [11:0] tgt_q, tgt_d;
    logic [6:0]  p1_q, p1_d;
    logic [9:0]  p_q, p_d;
    logic [9:0]  t_q, t_d;
    logic        tgt_ok_q, tgt_ok_d;
    logic        done_q, done_d;
    logic        verdict_q, verdict_d;
    logic        armed_q, armed_d;
    logic        judge_valid_q, judge_valid_d;
    logic        judge_ok_q, judge_ok_d;
    logic [1:0]  miss_q, miss_d;

    logic        in_input;
    logic        is_ready;
    logic [9:0]  conv_bin;
    logic        conv_ok;
    logic        unused_question_lsbs;

    assign in_input             = (STATE == GS_INPUT);
    assign is_ready             = (STATE == GS_READY);
    assign unused_question_lsbs = ^QUESTION[11:0];

    bcd3_to_bin u_bcd3_to_bin (
        .bcd       (tgt_q),
        .bin       (conv_bin),
        .digits_ok (conv_ok)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= JS_IDLE;
            a1_q          <= '0;
            a2_q          <= '0;
            a3_q          <= '0;
            tgt_q         <= '0;
            p1_q          <= '0;
            p_q           <= '0;
            t_q           <= '0;
            tgt_ok_q      <= 1'b0;
            done_q        <= 1'b0;
            verdict_q     <= 1'b0;
            armed_q       <= 1'b1;
            judge_valid_q <= 1'b0;
            judge_ok_q    <= 1'b0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            a1_q          <= a1_d;
            a2_q          <= a2_d;
            a3_q          <= a3_d;
            tgt_q         <= tgt_d;
            p1_q          <= p1_d;
            p_q           <= p_d;
            t_q           <= t_d;
            tgt_ok_q      <= tgt_ok_d;
            done_q        <= done_d;
            verdict_q     <= verdict_d;
            armed_q       <= armed_d;
            judge_valid_q <= judge_valid_d;
            judge_ok_q    <= judge_ok_d;
            miss_q        <= miss_d;
        end
    end

    // armed_q requires DEC to be seen low once before another start, so a held
    // DEC level counts as a single request.
    always_comb begin
        state_d       = state_q;
        a1_d          = a1_q;
        a2_d          = a2_q;
        a3_d          = a3_q;
        tgt_d         = tgt_q;
        p1_d          = p1_q;
        p_d           = p_q;
        t_d           = t_q;
        tgt_ok_d      = tgt_ok_q;
        done_d        = 1'b0;
        verdict_d     = verdict_q;
        armed_d       = armed_q;
        judge_valid_d = 1'b0;
        judge_ok_d    = judge_ok_q;
        miss_d        = miss_q;

        if (!DEC) begin
            armed_d = 1'b1;
        end

        case (state_q)
            JS_IDLE: begin
                if (in_input && DEC && armed_q) begin
                    state_d = JS_MUL1;
                    a1_d    = ANS1;
                    a2_d    = ANS2;
                    a3_d    = ANS3;
                    tgt_d   = QUESTION[23:12];
                    armed_d = 1'b0;
                end
            end
            JS_MUL1: begin
                p1_d    = {3'd0, a1_q} * {3'd0, a2_q};
                state_d = in_input ? JS_MUL2 : JS_IDLE;
            end
            JS_MUL2: begin
                p_d      = {3'd0, p1_q} * {6'd0, a3_q};
                t_d      = conv_bin;
                tgt_ok_d = conv_ok;
                state_d  = in_input ? JS_CMP : JS_IDLE;
            end
            JS_CMP: begin
                state_d = JS_IDLE;
                if (in_input) begin
                    done_d    = 1'b1;
                    verdict_d = (p_q == t_q) && tgt_ok_q &&
                                is_prime_digit(a1_q) && is_prime_digit(a2_q) &&
                                is_prime_digit(a3_q);
                end
            end
            default: begin
                state_d = JS_IDLE;
            end
        endcase

        // The verdict is published one edge after CMP; a READY on that edge
        // still lets the pulse through but overrides the miss count.
        if (done_q) begin
            judge_valid_d = 1'b1;
            judge_ok_d    = verdict_q;
            if (!verdict_q && (miss_q != MISS_MAX)) begin
                miss_d = miss_q + 2'd1;
            end
        end

        if (is_ready) begin
            miss_d = '0;
        end
    end

    assign BUSY        = (state_q != JS_IDLE);
    assign JUDGE_VALID = judge_valid_q;
    assign JUDGE_OK    = judge_ok_q;
    assign MISS_CNT    = miss_q;
    assign LOSE_FLAG   = (miss_q == MISS_MAX);

endmodule

// File: tb/tb_answer_judge.sv
// Self-checking bench for answer_judge: a cycle-level behavioural model checked
// every cycle, plus directed judgements with hand-computed verdicts.
module tb_answer_judge;

    localparam logic [3:0] ST_READY = 4'b0010;
    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam logic [3:0] ST_WRONG = 4'b0111;

    logic        CLK;
    logic        RST;
    logic [3:0]  STATE;
    logic [23:0] QUESTION;
    logic [3:0]  ANS1;
    logic [3:0]  ANS2;
    logic [3:0]  ANS3;
    logic        DEC;
    logic        BUSY;
    logic        JUDGE_VALID;
    logic        JUDGE_OK;
    logic [1:0]  MISS_CNT;
    logic        LOSE_FLAG;

    int checks = 0;
    int errors = 0;
    bit tb_active = 1'b0;

    answer_judge dut (
        .CLK         (CLK),
        .RST         (RST),
        .STATE       (STATE),
        .QUESTION    (QUESTION),
        .ANS1        (ANS1),
        .ANS2        (ANS2),
        .ANS3        (ANS3),
        .DEC         (DEC),
        .BUSY        (BUSY),
        .JUDGE_VALID (JUDGE_VALID),
        .JUDGE_OK    (JUDGE_OK),
        .MISS_CNT    (MISS_CNT),
        .LOSE_FLAG   (LOSE_FLAG)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] st, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic [3:0] a3, input logic [11:0] q, input logic dec);
        STATE    = st;
        ANS1     = a1;
        ANS2     = a2;
        ANS3     = a3;
        QUESTION = {q, 12'hA5A};
        DEC      = dec;
    endtask

    // Model: verdict from plain integer arithmetic and digit rules
    function automatic bit is_prime(input int d);
        return (d == 2) || (d == 3) || (d == 5) || (d == 7);
    endfunction

    function automatic bit model_verdict(input int a1, input int a2, input int a3,
                                         input int h, input int t, input int o);
        if (!(is_prime(a1) && is_prime(a2) && is_prime(a3))) return 1'b0;
        if (h > 9 || t > 9 || o > 9) return 1'b0;
        return (a1 * a2 * a3) == (h * 100 + t * 10 + o);
    endfunction

    int m_phase   = 0;
    bit m_armed   = 1'b1;
    int m_a1, m_a2, m_a3, m_h, m_t, m_o;
    bit m_pend    = 1'b0;
    bit m_pend_ok = 1'b0;
    bit e_valid   = 1'b0;
    bit e_ok      = 1'b0;
    int e_miss    = 0;

    // Timeline: start edge, three busy cycles, verdict published one edge later.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_phase = 0;
            m_armed = 1'b1;
            m_pend  = 1'b0;
            e_valid = 1'b0;
            e_ok    = 1'b0;
            e_miss  = 0;
        end else begin
            e_valid = 1'b0;
            if (m_pend) begin
                e_valid = 1'b1;
                e_ok    = m_pend_ok;
                if (!m_pend_ok && e_miss < 3) e_miss = e_miss + 1;
                m_pend = 1'b0;
            end
            if (STATE == ST_READY) e_miss = 0;
            if (m_phase != 0) begin
                if (STATE != ST_INPUT) begin
                    m_phase = 0;
                end else if (m_phase == 3) begin
                    m_phase   = 0;
                    m_pend    = 1'b1;
                    m_pend_ok = model_verdict(m_a1, m_a2, m_a3, m_h, m_t, m_o);
                end else begin
                    m_phase = m_phase + 1;
                end
            end else if (STATE == ST_INPUT && DEC && m_armed) begin
                m_a1    = int'(ANS1);
                m_a2    = int'(ANS2);
                m_a3    = int'(ANS3);
                m_h     = int'(QUESTION[23:20]);
                m_t     = int'(QUESTION[19:16]);
                m_o     = int'(QUESTION[15:12]);
                m_phase = 1;
                m_armed = 1'b0;
            end
            if (!DEC) m_armed = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (tb_active) begin
            checkOutput("model_busy", int'(BUSY), int'(m_phase != 0));
            checkOutput("model_valid", int'(JUDGE_VALID), int'(e_valid));
            checkOutput("model_ok", int'(JUDGE_OK), int'(e_ok));
            checkOutput("model_miss", int'(MISS_CNT), e_miss);
            checkOutput("model_lose", int'(LOSE_FLAG), int'(e_miss == 3));
        end
    end

    // Called on a falling edge; returns on the falling edge after the verdict.
    task automatic run_judge(input string name, input logic [3:0] a1, input logic [3:0] a2,
                             input logic [3:0] a3, input logic [11:0] q,
                             input int exp_ok, input int exp_miss);
        int n;
        applyStimulus(ST_INPUT, a1, a2, a3, q, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        DEC = 1'b0;
        checkOutput({name, "_busy"}, int'(BUSY), 1);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (JUDGE_VALID) begin
                n = i;
                break;
            end
        end
        checkOutput({name, "_latency"}, n, 4);
        checkOutput({name, "_ok"}, int'(JUDGE_OK), exp_ok);
        checkOutput({name, "_miss"}, int'(MISS_CNT), exp_miss);
        checkOutput({name, "_lose"}, int'(LOSE_FLAG), int'(exp_miss == 3));
    endtask

    initial begin
        int cnt;
        int okv;
        RST = 1'b1;
        applyStimulus(ST_READY, 4'd0, 4'd0, 4'd0, 12'h000, 1'b0);
        #2 RST = 1'b0;
        tb_active = 1'b1;
        #1;
        checkOutput("rst_busy", int'(BUSY), 0);
        checkOutput("rst_valid", int'(JUDGE_VALID), 0);
        checkOutput("rst_ok", int'(JUDGE_OK), 0);
        checkOutput("rst_miss", int'(MISS_CNT), 0);
        checkOutput("rst_lose", int'(LOSE_FLAG), 0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);

        run_judge("ok_357", 4'd3, 4'd5, 4'd7, 12'h105, 1, 0);
        run_judge("nonprime_234", 4'd2, 4'd3, 4'd4, 12'h024, 0, 1);
        run_judge("mismatch_235", 4'd2, 4'd3, 4'd5, 12'h031, 0, 2);
        run_judge("zero_digit", 4'd0, 4'd5, 4'd7, 12'h000, 0, 3);
        run_judge("bad_target_digit", 4'd5, 4'd5, 4'd5, 12'h0C5, 0, 3);
        run_judge("ok_at_max", 4'd7, 4'd7, 4'd7, 12'h343, 1, 3);

        STATE = ST_READY;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("ready_clear_miss", int'(MISS_CNT), 0);
        checkOutput("ready_clear_lose", int'(LOSE_FLAG), 0);

        applyStimulus(ST_INPUT, 4'd2, 4'd2, 4'd3, 12'h012, 1'b1);
        cnt = 0;
        okv = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (i == 10) DEC = 1'b0;
            if (JUDGE_VALID) begin
                cnt++;
                okv = int'(JUDGE_OK);
            end
        end
        checkOutput("hold_pulse_count", cnt, 1);
        checkOutput("hold_ok", okv, 1);

        applyStimulus(ST_INPUT, 4'd2, 4'd2, 4'd4, 12'h016, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        DEC = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        STATE = ST_WRONG;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("abort_busy", int'(BUSY), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (JUDGE_VALID) cnt++;
        end
        checkOutput("abort_no_valid", cnt, 0);
        checkOutput("abort_miss", int'(MISS_CNT), 0);
        STATE = ST_INPUT;
        @(negedge CLK);

        run_judge("pre_ready_win", 4'd2, 4'd3, 4'd4, 12'h024, 0, 1);
        applyStimulus(ST_INPUT, 4'd2, 4'd2, 4'd2, 12'h009, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        DEC = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        STATE = ST_READY;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("ready_win_valid", int'(JUDGE_VALID), 1);
        checkOutput("ready_win_ok", int'(JUDGE_OK), 0);
        checkOutput("ready_win_miss", int'(MISS_CNT), 0);
        STATE = ST_INPUT;
        @(negedge CLK);

        run_judge("pre_rst_wrong", 4'd2, 4'd3, 4'd4, 12'h024, 0, 1);
        run_judge("pre_rst_ok", 4'd2, 4'd3, 4'd5, 12'h030, 1, 1);
        applyStimulus(ST_INPUT, 4'd3, 4'd5, 4'd7, 12'h105, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        DEC = 1'b0;
        #2 RST = 1'b0;
        #1;
        checkOutput("midrst_busy", int'(BUSY), 0);
        checkOutput("midrst_valid", int'(JUDGE_VALID), 0);
        checkOutput("midrst_ok", int'(JUDGE_OK), 0);
        checkOutput("midrst_miss", int'(MISS_CNT), 0);
        checkOutput("midrst_lose", int'(LOSE_FLAG), 0);
        @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        run_judge("after_rst", 4'd3, 4'd5, 4'd7, 12'h105, 1, 0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/answer_judge.md
ANSWER_JUDGE -- requirements
Module: answer_judge

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports CLK and RST, with RST low = reset.
REQ-002 CLK  input  1  rising-edge system clock.
REQ-003 RST  input  1  asynchronous reset, active low.
REQ-004 STATE  input  4  game state code: READY=0010, QUE=0011, INPUT=0100, WRONG=0111, GOOD=1000, LOSE=1011.
REQ-005 QUESTION  input  24  target; [23:12] = 3 BCD digits (hundreds, tens, ones); [11:0] ignored.
REQ-006 ANS1, ANS2, ANS3  input  4 each  player's BCD factor digits, held stable by the input stage.
REQ-007 DEC  input  1  level decide request from the player.
REQ-008 BUSY  output  1  high while a judgement is in progress.
REQ-009 JUDGE_VALID  output  1  one-cycle pulse marking a finished judgement.
REQ-010 JUDGE_OK  output  1  verdict of the last judgement; valid with JUDGE_VALID, held until the next judgement.
REQ-011 MISS_CNT  output  2  count of wrong judgements, saturating.
REQ-012 LOSE_FLAG  output  1  high when MISS_CNT = 3.

Function
REQ-013 FSM states SHALL be IDLE, MUL1, MUL2, CMP, with transitions IDLE->MUL1->MUL2->CMP->IDLE.
REQ-014 IDLE->MUL1 SHALL occur on an edge where STATE=INPUT and DEC=1; at that edge ANS1..3 and QUESTION[23:12] are latched.
REQ-015 MUL1 SHALL compute P1 = A1*A2 (7 bits); MUL2 SHALL compute P = P1*A3 (10 bits, max 729) and convert the target with T = 100*h + 10*t + o (10 bits).
REQ-016 CMP SHALL set OK = (P == T) AND every latched digit is in {2,3,5,7} AND every target digit is <= 9.
REQ-017 JUDGE_VALID SHALL be high exactly one cycle, starting on the 4th rising edge after the DEC-sampling edge; JUDGE_OK SHALL update on the same edge.
REQ-018 BUSY SHALL be high in MUL1, MUL2 and CMP; DEC SHALL be ignored while BUSY, with no queueing.
REQ-019 DEC held high SHALL start a new judgement only after a return to IDLE with DEC having been low for at least one edge; a level hold is a single request.
REQ-020 Any digit equal to 0, 1 or a non-prime value SHALL yield JUDGE_OK=0; no multiplication shortcut is permitted that changes the latency.
REQ-021 A judgement with OK=0 SHALL increment MISS_CNT, saturating at 3; OK=1 SHALL leave MISS_CNT unchanged.
REQ-022 STATE=READY SHALL clear MISS_CNT to 0 synchronously.
REQ-023 If STATE leaves INPUT while BUSY, the FSM SHALL return to IDLE on the next edge, with no JUDGE_VALID pulse and no MISS_CNT change.
REQ-024 If a CMP completion and STATE=READY occur on the same edge, READY SHALL win: MISS_CNT is cleared, and JUDGE_VALID still pulses.
REQ-025 Arithmetic SHALL be unsigned with no truncation: P1 is 7 bits, and P and T are 10 bits.

Reset
REQ-026 RST low SHALL asynchronously force the FSM to IDLE and set BUSY=0, JUDGE_VALID=0, JUDGE_OK=0, MISS_CNT=0 and LOSE_FLAG=0.
REQ-027 Reset mid-judgement SHALL discard the operation; after RST rises, the first DEC edge starts a fresh judgement.

Structure
REQ-028 STATE codes and FSM state encodings SHALL reside in the shared package factor_pkg.
REQ-029 BCD-to-binary conversion SHALL be a sub-module, bcd3_to_bin: combinational, 12-bit BCD in, 10-bit binary out, plus a digit-valid flag.

Verification
REQ-030 STATE=INPUT, ANS=3,5,7, QUESTION[23:12]=0x105, DEC pulse -> JUDGE_VALID 4 edges later, JUDGE_OK=1, MISS_CNT=0.
REQ-031 ANS=2,3,4, target 0x024 -> JUDGE_OK=0 (4 is not prime), MISS_CNT=1.
REQ-032 Three wrong judgements followed by a fourth -> MISS_CNT=3 and LOSE_FLAG=1 after the third, unchanged after the fourth; STATE=READY -> MISS_CNT=0.
REQ-033 DEC pulse, then STATE=WRONG at the MUL2 edge -> no JUDGE_VALID, BUSY=0 next cycle, MISS_CNT unchanged.
REQ-034 DEC held high for 10 cycles with ANS=2,2,3 and target 0x012 -> exactly one JUDGE_VALID with JUDGE_OK=1.
REQ-035 RST low during MUL1 -> all outputs 0 immediately, without waiting for a clock edge; first DEC after release -> normal 4-edge latency.
